// File: rtl/sdp_ram_pipelined.sv
// Simple dual-port RAM: byte-masked write port A and read port B with a configurable read latency.
// Out-of-range addresses are guarded, and the read-during-write collision mode is selectable.
module sdp_ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wena,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic                    renb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    dvalb,
  output logic                    oorb
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if ((READ_LATENCY < 1) || (READ_LATENCY > 4) || ((DATA_WIDTH % 8) != 0) ||
      (MEM_DEPTH < 1) || (MEM_DEPTH > (2 ** ADDR_WIDTH))) begin : g_param_check
    $error("sdp_ram_pipelined: illegal parameter combination");
  end

  // Word with the enabled bytes taken from new_word and the rest from old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  logic                  wr_hit_s;
  logic                  rd_in_range_s;
  logic [DATA_WIDTH-1:0] rd_raw_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  rd_oor_s;

  logic                  out_in_val_s;
  logic [DATA_WIDTH-1:0] out_in_data_s;
  logic                  out_in_oor_s;

  logic [DATA_WIDTH-1:0] doutb_r;
  logic                  dvalb_r;
  logic                  oorb_r;

  assign rd_raw_s = mem_r[addrb[IDX_W-1:0]];

  // Address range qualification for both ports
  always_comb begin
    wr_hit_s      = wena && ({1'b0, addra} < DEPTH_L);
    rd_in_range_s = ({1'b0, addrb} < DEPTH_L);
  end

  // Read word as seen at the sampling edge, including the collision policy
  always_comb begin
    rd_word_s = '0;
    rd_oor_s  = 1'b0;
    if (!rd_in_range_s) begin
      rd_word_s = '0;
      rd_oor_s  = 1'b1;
    end else if ((RDW_MODE == 1) && wr_hit_s && (addra == addrb)) begin
      rd_word_s = merge_bytes(rd_raw_s, dina, wbe);
      rd_oor_s  = 1'b0;
    end else begin
      rd_word_s = rd_raw_s;
      rd_oor_s  = 1'b0;
    end
  end

  // Byte-masked array write; storage itself is never reset
  always_ff @(posedge clk) begin
    if (!rst && wr_hit_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) begin
          mem_r[addra[IDX_W-1:0]][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign out_in_val_s  = renb;
    assign out_in_data_s = rd_word_s;
    assign out_in_oor_s  = rd_oor_s;
  end else begin : g_pipe
    localparam int N = READ_LATENCY - 1;

    logic                  pipe_val_r  [N];
    logic [DATA_WIDTH-1:0] pipe_data_r [N];
    logic                  pipe_oor_r  [N];

    // Delay line between the array read and the output register
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < N; k++) begin
          pipe_val_r[k]  <= 1'b0;
          pipe_data_r[k] <= '0;
          pipe_oor_r[k]  <= 1'b0;
        end
      end else begin
        pipe_val_r[0] <= renb;
        if (renb) begin
          pipe_data_r[0] <= rd_word_s;
          pipe_oor_r[0]  <= rd_oor_s;
        end
        for (int k = 1; k < N; k++) begin
          pipe_val_r[k]  <= pipe_val_r[k-1];
          pipe_data_r[k] <= pipe_data_r[k-1];
          pipe_oor_r[k]  <= pipe_oor_r[k-1];
        end
      end
    end

    assign out_in_val_s  = pipe_val_r[N-1];
    assign out_in_data_s = pipe_data_r[N-1];
    assign out_in_oor_s  = pipe_oor_r[N-1];
  end

  // Output register: doutb only moves together with a dvalb strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb_r <= '0;
      dvalb_r <= 1'b0;
      oorb_r  <= 1'b0;
    end else begin
      dvalb_r <= out_in_val_s;
      oorb_r  <= out_in_val_s && out_in_oor_s;
      if (out_in_val_s) begin
        doutb_r <= out_in_data_s;
      end
    end
  end

  assign doutb = doutb_r;
  assign dvalb = dvalb_r;
  assign oorb  = oorb_r;

endmodule

// File: tb/tb_sdp_ram_pipelined.sv
// Directed bench for sdp_ram_pipelined: four instances that share stimulus but differ in
// latency, collision mode and depth, each with hand-computed expected read streams.
module tb_sdp_ram_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wena, renb;
  logic [3:0]  wbe;
  logic [7:0]  addra, addrb;
  logic [31:0] dina;

  logic [31:0] doutb_a [4];
  logic        dvalb_a [4];
  logic        oorb_a  [4];

  int          lat_a [4] = '{1, 2, 3, 4};
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          e1 = 0;

  int          rec_n    [4];
  int          rec_cyc  [4][16];
  logic [31:0] rec_data [4][16];
  logic        rec_oor  [4][16];

  int          exp_n    [4];
  logic [31:0] exp_d    [4][8];
  logic        exp_oor  [4][8];

  sdp_ram_pipelined #(.READ_LATENCY(1), .RDW_MODE(1)) u_l1 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[0]), .dvalb(dvalb_a[0]), .oorb(oorb_a[0]));
  sdp_ram_pipelined #(.READ_LATENCY(2), .RDW_MODE(0)) u_l2 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[1]), .dvalb(dvalb_a[1]), .oorb(oorb_a[1]));
  sdp_ram_pipelined #(.READ_LATENCY(3), .RDW_MODE(1)) u_l3 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[2]), .dvalb(dvalb_a[2]), .oorb(oorb_a[2]));
  sdp_ram_pipelined #(.READ_LATENCY(4), .RDW_MODE(0), .MEM_DEPTH(200)) u_l4 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb_a[3]), .dvalb(dvalb_a[3]), .oorb(oorb_a[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then log every strobed output word per instance.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (dvalb_a[i] === 1'b1) begin
        if (rec_n[i] < 16) begin
          rec_cyc[i][rec_n[i]]  = cyc;
          rec_data[i][rec_n[i]] = doutb_a[i];
          rec_oor[i][rec_n[i]]  = oorb_a[i];
        end
        rec_n[i]++;
      end
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      rec_n[i] = 0;
      exp_n[i] = 0;
      for (int k = 0; k < 8; k++) exp_oor[i][k] = 1'b0;
    end
  endtask

  task automatic idle();
    wena = 1'b0; renb = 1'b0; wbe = 4'h0;
    addra = 8'd0; addrb = 8'd0; dina = 32'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wena = 1'b1; addra = a; dina = d; wbe = be;
    tick();
    wena = 1'b0; wbe = 4'h0;
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  task automatic exp_all(input int n, input int k, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      exp_n[i]    = n;
      exp_d[i][k] = d;
    end
  endtask

  // Compare the logged stream of each instance against the expectation tables.
  task automatic expect_stream(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_i%0d_count", tag, i), rec_n[i], exp_n[i]);
      for (int k = 0; k < exp_n[i]; k++) begin
        if (k < rec_n[i]) begin
          chk($sformatf("%s_i%0d_k%0d_cyc", tag, i, k), rec_cyc[i][k], e1 + lat_a[i] - 1 + k);
          chk($sformatf("%s_i%0d_k%0d_data", tag, i, k), rec_data[i][k], exp_d[i][k]);
          chk($sformatf("%s_i%0d_k%0d_oor", tag, i, k), rec_oor[i][k], exp_oor[i][k]);
        end
      end
    end
  endtask

  task automatic read_one(input logic [7:0] a);
    renb = 1'b1; addrb = a;
    tick();
    e1 = cyc;
    renb = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    clr();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_i%0d_doutb", i), doutb_a[i], 32'h0);
      chk($sformatf("rst_i%0d_dvalb", i), dvalb_a[i], 32'h0);
      chk($sformatf("rst_i%0d_oorb", i), oorb_a[i], 32'h0);
    end
    rst = 1'b0;
    tick();

    // Single read with latency and hold
    wr(8'd5, 32'hDEADBEEF, 4'hF);
    clr();
    read_one(8'd5);
    drain();
    exp_all(1, 0, 32'hDEADBEEF);
    expect_stream("t1");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_i%0d_hold", i), doutb_a[i], 32'hDEADBEEF);
      chk($sformatf("t1_i%0d_dvalb_low", i), dvalb_a[i], 32'h0);
    end

    // Byte enables and the wbe=0 no-op
    wr(8'd9, 32'h11223344, 4'hF);
    wr(8'd9, 32'hAABBCCDD, 4'b0101);
    wr(8'd9, 32'hFFFFFFFF, 4'b0000);
    clr();
    read_one(8'd9);
    drain();
    exp_all(1, 0, 32'h11BB33DD);
    expect_stream("t2");

    // Write at E2 must not alter data captured at E1
    clr();
    read_one(8'd9);
    wr(8'd9, 32'h00000000, 4'hF);
    drain();
    exp_all(1, 0, 32'h11BB33DD);
    expect_stream("war");

    // Full-word collision: odd instances write-first, even read-first
    wr(8'd3, 32'h00000000, 4'hF);
    clr();
    wena = 1'b1; addra = 8'd3; dina = 32'h5A5A5A5A; wbe = 4'hF;
    read_one(8'd3);
    wena = 1'b0; wbe = 4'h0;
    drain();
    exp_all(1, 0, 32'h00000000);
    exp_d[0][0] = 32'h5A5A5A5A;
    exp_d[2][0] = 32'h5A5A5A5A;
    expect_stream("t3_coll");
    clr();
    read_one(8'd3);
    drain();
    exp_all(1, 0, 32'h5A5A5A5A);
    expect_stream("t3_after");

    // Partial-byte collision returns the merged word in write-first mode
    clr();
    wena = 1'b1; addra = 8'd3; dina = 32'h12345678; wbe = 4'b0011;
    read_one(8'd3);
    wena = 1'b0; wbe = 4'h0;
    drain();
    exp_all(1, 0, 32'h5A5A5A5A);
    exp_d[0][0] = 32'h5A5A5678;
    exp_d[2][0] = 32'h5A5A5678;
    expect_stream("t3_merge");

    // Back-to-back reads of 0..7
    for (int a = 0; a < 8; a++) wr(8'(a), 32'hC0DE0000 | 32'(a), 4'hF);
    clr();
    renb = 1'b1;
    for (int a = 0; a < 8; a++) begin
      addrb = 8'(a);
      tick();
      if (a == 0) e1 = cyc;
    end
    renb = 1'b0;
    drain();
    for (int k = 0; k < 8; k++) exp_all(8, k, 32'hC0DE0000 | 32'(k));
    expect_stream("t4");

    // Reset one cycle after the first of three reads; write during reset is blocked
    clr();
    renb = 1'b1; addrb = 8'd0;
    tick();
    e1 = cyc;
    rst = 1'b1; addrb = 8'd1;
    wena = 1'b1; addra = 8'd0; dina = 32'hFFFFFFFF; wbe = 4'hF;
    tick();
    addrb = 8'd2;
    tick();
    rst = 1'b0;
    idle();
    drain();
    exp_all(0, 0, 32'h0);
    exp_n[0] = 1;
    exp_d[0][0] = 32'hC0DE0000;
    expect_stream("t5_rst");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_i%0d_doutb0", i), doutb_a[i], 32'h0);
      chk($sformatf("t5_i%0d_oorb0", i), oorb_a[i], 32'h0);
    end
    clr();
    renb = 1'b1;
    for (int a = 0; a < 3; a++) begin
      addrb = 8'(a);
      tick();
      if (a == 0) e1 = cyc;
    end
    renb = 1'b0;
    drain();
    for (int k = 0; k < 3; k++) exp_all(3, k, 32'hC0DE0000 | 32'(k));
    expect_stream("t5_reread");

    // Out-of-range on the 200-deep instance: writes dropped, reads answered with oorb
    wr(8'd50, 32'h50505050, 4'hF);
    wr(8'd250, 32'hFACEFACE, 4'hF);
    wr(8'd200, 32'h20020020, 4'hF);
    wr(8'd199, 32'h19919919, 4'hF);
    clr();
    renb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: addrb = 8'd250;
        1: addrb = 8'd50;
        2: addrb = 8'd200;
        3: addrb = 8'd199;
        default: addrb = 8'd0;
      endcase
      tick();
      if (k == 0) e1 = cyc;
    end
    renb = 1'b0;
    drain();
    exp_all(5, 0, 32'hFACEFACE);
    exp_all(5, 1, 32'h50505050);
    exp_all(5, 2, 32'h20020020);
    exp_all(5, 3, 32'h19919919);
    exp_all(5, 4, 32'hC0DE0000);
    exp_d[3][0] = 32'h0; exp_oor[3][0] = 1'b1;
    exp_d[3][2] = 32'h0; exp_oor[3][2] = 1'b1;
    expect_stream("t6");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_i%0d_oorb_low", i), oorb_a[i], 32'h0);
      chk($sformatf("t6_i%0d_hold", i), doutb_a[i], 32'hC0DE0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
